// File: rtl/branch_resolve_queue.sv
// In-order branch tracking queue: holds fetch predictions, compares them with
// execute outcomes, trains the predictor and redirects fetch on a mispredict.
module branch_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  input  logic [31:0]              enq_pc,
  input  logic                     enq_pred,
  output logic                     enq_ready,
  input  logic                     res_valid,
  input  logic                     res_taken,
  input  logic [31:0]              res_target,
  output logic                     upd_write,
  output logic [31:0]              upd_pc,
  output logic                     upd_value,
  output logic                     mispredict,
  output logic [31:0]              redirect_pc,
  output logic                     protocol_err,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         branch_cnt,
  output logic [CNT_W-1:0]         mispred_cnt
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Handshake: an enqueue is accepted on a rising edge where enq_valid and
  // enq_ready are both high; a resolve always refers to the oldest entry.
  logic [31:0]      pc_mem [DEPTH];
  logic [DEPTH-1:0] pred_mem;
  logic [PW-1:0]    head, tail;
  logic             full, empty, do_enq, do_res, mis, head_pred;
  logic [31:0]      head_pc, redirect_next;

  assign full          = (count == CW'(DEPTH));
  assign empty         = (count == '0);
  assign enq_ready     = !full;
  assign do_enq        = enq_valid && !full;
  assign do_res        = res_valid && !empty;
  assign head_pc       = pc_mem[head];
  assign head_pred     = pred_mem[head];
  assign mis           = do_res && (res_taken != head_pred);
  assign redirect_next = res_taken ? res_target : head_pc + 32'd4;

  // Entry storage needs no reset: occupancy alone says which slots are live.
  always_ff @(posedge clk) begin
    if (do_enq && !mis) begin
      pc_mem[tail]   <= enq_pc;
      pred_mem[tail] <= enq_pred;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (mis) begin
      // A mispredict squashes everything younger, including a same-cycle enqueue.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) tail <= tail + PW'(1);
      if (do_res) head <= head + PW'(1);
      count <= count + CW'(do_enq) - CW'(do_res);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_write    <= 1'b0;
      upd_pc       <= '0;
      upd_value    <= 1'b0;
      mispredict   <= 1'b0;
      redirect_pc  <= '0;
      protocol_err <= 1'b0;
    end else begin
      upd_write    <= do_res;
      upd_pc       <= do_res ? head_pc : '0;
      upd_value    <= do_res ? res_taken : 1'b0;
      mispredict   <= mis;
      redirect_pc  <= mis ? redirect_next : '0;
      protocol_err <= res_valid && empty;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (do_res && (branch_cnt != '1)) branch_cnt <= branch_cnt + CNT_W'(1);
      if (mis && (mispred_cnt != '1))   mispred_cnt <= mispred_cnt + CNT_W'(1);
    end
  end
endmodule
